// File: rtl/y86_pkg.sv
// y86_pkg: shared constants, entry type and write-rule helpers for the Y86 writeback stage
package y86_pkg;
   localparam int REG_W = 4;
   localparam int WORD_W = 32;
   localparam logic [REG_W-1:0] RNONE = 4'hF;
   localparam logic [2:0] STAT_AOK = 3'd1;
   localparam logic [2:0] STAT_HLT = 3'd2;
   localparam logic [2:0] STAT_ADR = 3'd3;
   localparam logic [2:0] STAT_INS = 3'd4;

   typedef struct packed {
      logic [REG_W-1:0]  dstE;
      logic [WORD_W-1:0] valE;
      logic [REG_W-1:0]  dstM;
      logic [WORD_W-1:0] valM;
      logic [2:0]        stat;
   } wb_entry_t;

   // E port yields to M when both target the same register (popl %esp)
   function automatic logic wr_e(wb_entry_t e);
      return e.dstE != RNONE && e.stat == STAT_AOK && e.dstE != e.dstM;
   endfunction

   function automatic logic wr_m(wb_entry_t e);
      return e.dstM != RNONE && e.stat == STAT_AOK;
   endfunction

   function automatic logic [7:0] reg_bit(logic [REG_W-1:0] r);
      return r[3] ? 8'h00 : 8'h01 << r[2:0];
   endfunction

   function automatic logic [7:0] ent_mask(wb_entry_t e);
      return (wr_e(e) ? reg_bit(e.dstE) : 8'h00) | (wr_m(e) ? reg_bit(e.dstM) : 8'h00);
   endfunction
endpackage

// File: rtl/y86_writeback_if.sv
// y86_writeback_if: retiring-instruction handshake from the memory stage into writeback
interface y86_writeback_if;
   import y86_pkg::*;
   logic              in_valid;
   logic              in_ready;
   logic [REG_W-1:0]  in_dstE;
   logic [WORD_W-1:0] in_valE;
   logic [REG_W-1:0]  in_dstM;
   logic [WORD_W-1:0] in_valM;
   logic [2:0]        in_stat;
   modport master (output in_valid, in_dstE, in_valE, in_dstM, in_valM, in_stat, input in_ready);
   modport slave (input in_valid, in_dstE, in_valE, in_dstM, in_valM, in_stat, output in_ready);
endinterface

// File: rtl/y86_wb_fifo.sv
// y86_wb_fifo: DEPTH-entry retire buffer with per-slot valid flags and pending-write masks
module y86_wb_fifo
   import y86_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       push_i,
   input  wb_entry_t  din_i,
   input  logic       pop_i,
   output wb_entry_t  head_o,
   output logic [7:0] msk_o [DEPTH],
   output logic [DEPTH-1:0] vld_o,
   output logic       full_o,
   output logic       empty_o
);
   localparam int AW = $clog2(DEPTH);
   wb_entry_t mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [AW:0] cnt_q, cnt_d;
   logic [DEPTH-1:0] vld_q, vld_d;

   // occupancy and slot flags; a simultaneous push and pop leaves the count unchanged
   always_comb begin
      cnt_d = cnt_q + {{AW{1'b0}}, push_i} - {{AW{1'b0}}, pop_i};
      vld_d = vld_q;
      if (pop_i) vld_d[rd_q] = 1'b0;
      if (push_i) vld_d[wr_q] = 1'b1;
   end

   // entry storage; a slot's contents matter only while its valid flag is set
   always_ff @(posedge clk)
      if (push_i) mem_q[wr_q] <= din_i;

   // pointers wrap naturally since DEPTH is a power of two
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
         vld_q <= '0;
      end else begin
         wr_q  <= wr_q + AW'(push_i);
         rd_q  <= rd_q + AW'(pop_i);
         cnt_q <= cnt_d;
         vld_q <= vld_d;
      end

   // effective register writes each stored entry will perform
   always_comb
      for (int i = 0; i < DEPTH; i++) msk_o[i] = ent_mask(mem_q[i]);

   assign head_o  = mem_q[rd_q];
   assign vld_o   = vld_q;
   assign full_o  = cnt_q == (AW+1)'(DEPTH);
   assign empty_o = cnt_q == '0;
endmodule

// File: rtl/y86_writeback.sv
// y86_writeback: buffers retiring instructions and drains them onto the dual-port register file
module y86_writeback
   import y86_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   y86_writeback_if.slave    in_if,
   input  logic              rf_stall_i,
   output logic              write1_o,
   output logic [REG_W-1:0]  register1_o,
   output logic [WORD_W-1:0] value1_o,
   output logic              write2_o,
   output logic [REG_W-1:0]  register2_o,
   output logic [WORD_W-1:0] value2_o,
   output logic [7:0]        pending_mask_o,
   output logic              halted_o,
   output logic [31:0]       retired_count_o
);
   wb_entry_t din, head;
   logic [7:0] msk [DEPTH];
   logic [DEPTH-1:0] vld;
   logic full, empty, push, pop;
   logic w1_q, w1_d, w2_q, w2_d, halt_q, halt_d, stop_q, stop_d;
   logic [REG_W-1:0] r1_q, r1_d, r2_q, r2_d;
   logic [WORD_W-1:0] v1_q, v1_d, v2_q, v2_d;
   logic [31:0] cnt_q, cnt_d;

   assign din = {in_if.in_dstE, in_if.in_valE, in_if.in_dstM, in_if.in_valM, in_if.in_stat};
   assign in_if.in_ready = reset_n && !full && !halt_q && !stop_q;
   assign push = in_if.in_valid && in_if.in_ready;
   assign pop  = !empty && !rf_stall_i;

   y86_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk(clk), .reset_n(reset_n), .push_i(push), .din_i(din), .pop_i(pop),
      .head_o(head), .msk_o(msk), .vld_o(vld), .full_o(full), .empty_o(empty)
   );

   // port values follow the popped head and hold while stalled; acceptance closes once a non-AOK entry is taken
   always_comb begin
      w1_d   = pop && wr_e(head);
      w2_d   = pop && wr_m(head);
      r1_d   = pop ? head.dstE : r1_q;
      v1_d   = pop ? head.valE : v1_q;
      r2_d   = pop ? head.dstM : r2_q;
      v2_d   = pop ? head.valM : v2_q;
      halt_d = halt_q || (pop && head.stat != STAT_AOK);
      stop_d = stop_q || (push && in_if.in_stat != STAT_AOK);
      cnt_d  = cnt_q + 32'(pop);
   end

   // registered port outputs, sticky status and retire counter
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         w1_q   <= 1'b0;
         w2_q   <= 1'b0;
         r1_q   <= '0;
         v1_q   <= '0;
         r2_q   <= '0;
         v2_q   <= '0;
         halt_q <= 1'b0;
         stop_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         w1_q   <= w1_d;
         w2_q   <= w2_d;
         r1_q   <= r1_d;
         v1_q   <= v1_d;
         r2_q   <= r2_d;
         v2_q   <= v2_d;
         halt_q <= halt_d;
         stop_q <= stop_d;
         cnt_q  <= cnt_d;
      end

   // scoreboard: writes still queued plus the ones on the ports this cycle
   always_comb begin
      pending_mask_o = (w1_q ? reg_bit(r1_q) : 8'h00) | (w2_q ? reg_bit(r2_q) : 8'h00);
      for (int i = 0; i < DEPTH; i++) pending_mask_o = pending_mask_o | (vld[i] ? msk[i] : 8'h00);
   end

   assign write1_o        = w1_q;
   assign register1_o     = r1_q;
   assign value1_o        = v1_q;
   assign write2_o        = w2_q;
   assign register2_o     = r2_q;
   assign value2_o        = v2_q;
   assign halted_o        = halt_q;
   assign retired_count_o = cnt_q;
endmodule
